// File: rtl/cam_pattern_tx.sv
// Camera-sensor emulator: drives PCLK/VSYNC/HREF and RGB565 bytes (high byte first)
// for QVGA-style frames of selectable test patterns.
module cam_pattern_tx #(
   parameter int unsigned PCLK_HALF = 1,
   parameter int unsigned H_ACT     = 320,
   parameter int unsigned H_BLANK   = 144,
   parameter int unsigned V_SYNC    = 3,
   parameter int unsigned V_BACK    = 17,
   parameter int unsigned V_ACT     = 240,
   parameter int unsigned V_FRONT   = 10
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic [1:0] MODE,
   output logic       PCLK,
   output logic       CamVsync,
   output logic       CamHsync,
   output logic [7:0] CamData,
   output logic [7:0] FrameCount,
   output logic       Busy
);

   localparam int unsigned LINE    = 2 * H_ACT + H_BLANK;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
   localparam int unsigned BAR_W   = H_ACT / 8;
   localparam int unsigned DIV_W   = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;
   localparam int unsigned BC_W    = $clog2(LINE);
   localparam int unsigned LN_W    = $clog2(V_TOTAL);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PCLK_HALF - 1);
   localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(LINE - 1);
   localparam logic [BC_W-1:0]  H_END     = BC_W'(2 * H_ACT);
   localparam logic [LN_W-1:0]  LN_LAST   = LN_W'(V_TOTAL - 1);
   localparam logic [LN_W-1:0]  BACK_LN   = LN_W'(V_SYNC);
   localparam logic [LN_W-1:0]  ACT_LN    = LN_W'(V_SYNC + V_BACK);
   localparam logic [LN_W-1:0]  FRONT_LN  = LN_W'(V_SYNC + V_BACK + V_ACT);

   typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              pclk_q, pclk_d;
   logic [BC_W-1:0]   bc_q, bc_d;
   logic [LN_W-1:0]   ln_q, ln_d;
   logic [1:0]        mode_q, mode_d;
   logic [5:0]        fid_q, fid_d;
   logic [7:0]        fc_q, fc_d;
   logic              busy_q, busy_d;
   logic              vsync_q, vsync_d;
   logic              hsync_q, hsync_d;
   logic [7:0]        data_q, data_d;
   logic              fall_tick;
   logic              start;
   logic [15:0]       pix;

   function automatic logic [15:0] pattern_pix(input logic [1:0]  mode,
                                               input logic [15:0] x,
                                               input logic [15:0] y,
                                               input logic [5:0]  fid);
      logic [15:0] bar;
      bar = x / 16'(BAR_W);
      pattern_pix = 16'h0000;
      case (mode)
         2'd0: begin
            case (bar)
               16'd0:   pattern_pix = 16'hFFFF;
               16'd1:   pattern_pix = 16'hFFE0;
               16'd2:   pattern_pix = 16'h07FF;
               16'd3:   pattern_pix = 16'h07E0;
               16'd4:   pattern_pix = 16'hF81F;
               16'd5:   pattern_pix = 16'hF800;
               16'd6:   pattern_pix = 16'h001F;
               default: pattern_pix = 16'h0000;
            endcase
         end
         2'd1:    pattern_pix = {x[7:3], x[7:2], x[7:3]};
         2'd2:    pattern_pix = (((x ^ y) & 16'h0010) != 16'h0000) ? 16'hFFFF : 16'h0000;
         default: pattern_pix = {5'h00, fid, 5'h00};
      endcase
   endfunction

   assign fall_tick = pclk_q && (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      pclk_d  = pclk_q;
      bc_d    = bc_q;
      ln_d    = ln_q;
      mode_d  = mode_q;
      fid_d   = fid_q;
      fc_d    = fc_q;
      busy_d  = busy_q;
      vsync_d = vsync_q;
      hsync_d = hsync_q;
      data_d  = data_q;
      start   = 1'b0;
      pix     = 16'h0000;

      if (div_q == DIV_LAST) begin
         div_d  = '0;
         pclk_d = ~pclk_q;
      end else begin
         div_d = div_q + 1'b1;
      end

      // Everything visible on the camera bus moves only when PCLK falls.
      if (fall_tick) begin
         if (state_q == StIdle) begin
            start = EN;
         end else begin
            if (bc_q == BC_LAST) begin
               bc_d = '0;
               if (ln_q == LN_LAST) begin
                  ln_d  = '0;
                  fc_d  = fc_q + 8'd1;
                  start = EN;
                  if (!EN) begin
                     state_d = StIdle;
                     busy_d  = 1'b0;
                  end
               end else begin
                  ln_d = ln_q + 1'b1;
               end
            end else begin
               bc_d = bc_q + 1'b1;
            end
            if (state_d != StIdle) begin
               if (ln_d < BACK_LN)       state_d = StVsync;
               else if (ln_d < ACT_LN)   state_d = StVback;
               else if (ln_d < FRONT_LN) state_d = StActive;
               else                      state_d = StVfront;
            end
         end

         if (start) begin
            state_d = StVsync;
            mode_d  = MODE;
            fid_d   = fc_d[5:0];
            busy_d  = 1'b1;
            bc_d    = '0;
            ln_d    = '0;
         end

         pix     = pattern_pix(mode_d, 16'(bc_d >> 1), 16'(ln_d) - 16'(ACT_LN), fid_d);
         vsync_d = (state_d == StVsync);
         hsync_d = (state_d == StActive) && (bc_d < H_END);
         data_d  = hsync_d ? (bc_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         div_q   <= '0;
         pclk_q  <= 1'b0;
         bc_q    <= '0;
         ln_q    <= '0;
         mode_q  <= 2'd0;
         fid_q   <= 6'd0;
         fc_q    <= 8'd0;
         busy_q  <= 1'b0;
         vsync_q <= 1'b0;
         hsync_q <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         pclk_q  <= pclk_d;
         bc_q    <= bc_d;
         ln_q    <= ln_d;
         mode_q  <= mode_d;
         fid_q   <= fid_d;
         fc_q    <= fc_d;
         busy_q  <= busy_d;
         vsync_q <= vsync_d;
         hsync_q <= hsync_d;
         data_q  <= data_d;
      end
   end

   assign PCLK       = pclk_q;
   assign CamVsync   = vsync_q;
   assign CamHsync   = hsync_q;
   assign CamData    = data_q;
   assign FrameCount = fc_q;
   assign Busy       = busy_q;

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Directed bench: captures the camera bus on PCLK rising edges and checks timing and pixels.
module tb_cam_pattern_tx;

   localparam int H_ACT   = 40;
   localparam int H_BLANK = 4;
   localparam int V_SYNC  = 2;
   localparam int V_BACK  = 1;
   localparam int V_ACT   = 20;
   localparam int V_FRONT = 1;
   localparam int LINE    = 2 * H_ACT + H_BLANK;
   localparam int FRAME   = LINE * (V_SYNC + V_BACK + V_ACT + V_FRONT);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       pclk, vsync, hsync, busy;
   logic [7:0] data, fc;

   logic       pclk3, vsync3, hsync3, busy3;
   logic [7:0] data3, fc3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cam_pattern_tx #(
      .PCLK_HALF(1), .H_ACT(H_ACT), .H_BLANK(H_BLANK), .V_SYNC(V_SYNC),
      .V_BACK(V_BACK), .V_ACT(V_ACT), .V_FRONT(V_FRONT)
   ) dut (
      .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .PCLK(pclk), .CamVsync(vsync),
      .CamHsync(hsync), .CamData(data), .FrameCount(fc), .Busy(busy)
   );

   cam_pattern_tx #(
      .PCLK_HALF(3), .H_ACT(8), .H_BLANK(2), .V_SYNC(1), .V_BACK(1), .V_ACT(2), .V_FRONT(1)
   ) dut3 (
      .CLK(clk), .RST(rst), .EN(1'b1), .MODE(2'd0), .PCLK(pclk3), .CamVsync(vsync3),
      .CamHsync(hsync3), .CamData(data3), .FrameCount(fc3), .Busy(busy3)
   );

   // Receiver-side capture model for the main instance.
   logic        pclk_prev = 1'b0, prev_vs = 1'b0, prev_hs = 1'b0;
   logic [7:0]  hi_byte = 8'h00;
   logic [15:0] cap [0:V_ACT-1][0:H_ACT-1];
   int row = -1, bytecnt = 0, href_len = 0, href_pulses = 0, low_run = 0, low_gap = 0;
   int vs_len = 0, vs_rises = 0, rises = 0, last_vs_rise = 0, frame_period = 0;
   int clk_since_rise = 0, pclk_period = 0, stray = 0;

   always @(negedge clk) begin
      pclk_prev <= pclk;
      if (pclk && !pclk_prev) begin
         pclk_period    <= clk_since_rise;
         clk_since_rise <= 1;
         rises          <= rises + 1;
         prev_vs        <= vsync;
         prev_hs        <= hsync;
         if (vsync && !prev_vs) begin
            vs_len       <= 1;
            row          <= -1;
            href_pulses  <= 0;
            vs_rises     <= vs_rises + 1;
            frame_period <= rises - last_vs_rise;
            last_vs_rise <= rises;
         end else if (vsync) begin
            vs_len <= vs_len + 1;
         end
         if (hsync) begin
            low_run <= 0;
            if (!prev_hs) begin
               row     <= row + 1;
               bytecnt <= 1;
               hi_byte <= data;
               if (low_run > 0) low_gap <= low_run;
            end else begin
               if (bytecnt % 2 == 0) hi_byte <= data;
               else if (row >= 0 && row < V_ACT && (bytecnt >> 1) < H_ACT)
                  cap[row][bytecnt >> 1] <= {hi_byte, data};
               bytecnt <= bytecnt + 1;
            end
         end else begin
            if (prev_hs) begin
               href_len    <= bytecnt;
               href_pulses <= href_pulses + 1;
            end
            low_run <= low_run + 1;
            if (data != 8'h00) stray <= stray + 1;
         end
      end else begin
         clk_since_rise <= clk_since_rise + 1;
      end
   end

   // Slow-PCLK instance: bus changes must coincide with PCLK falling.
   logic       p3_prev = 1'b0, hs3_prev = 1'b0, r1 = 1'b1, r2 = 1'b1;
   logic [7:0] d3_prev = 8'h00;
   int trans3 = 0, viol3 = 0, since3 = 0, period3 = 0;

   always @(negedge clk) begin
      p3_prev  <= pclk3;
      hs3_prev <= hsync3;
      d3_prev  <= data3;
      r1       <= rst;
      r2       <= r1;
      if (!rst && !r1 && !r2 && (hsync3 != hs3_prev || data3 != d3_prev)) begin
         trans3 <= trans3 + 1;
         if (!(p3_prev && !pclk3)) viol3 <= viol3 + 1;
      end
      if (pclk3 && !p3_prev) begin
         period3 <= since3;
         since3  <= 1;
      end else begin
         since3 <= since3 + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_fc(input string tag, input logic [7:0] target);
      int n = 0;
      while (fc != target && n < 3 * 2 * FRAME) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq(tag, 32'(fc), 32'(target));
   endtask

   task automatic wait_vs_rises(input int target);
      int n = 0;
      while (vs_rises < target && n < 3 * 2 * FRAME) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("vsync_rise_seen", 32'(vs_rises), 32'(target));
   endtask

   task automatic wait_row(input int target);
      int n = 0;
      while (row < target && n < 3 * 2 * FRAME) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("row_reached", 32'(row >= target), 32'd1);
   endtask

   initial begin
      int n;
      repeat (4) @(posedge clk);
      #1;
      check_eq("rst_pclk", 32'(pclk), 32'd0);
      check_eq("rst_vsync", 32'(vsync), 32'd0);
      check_eq("rst_hsync", 32'(hsync), 32'd0);
      check_eq("rst_data", 32'(data), 32'd0);
      check_eq("rst_fc", 32'(fc), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      en  = 1'b1;

      // Frame 1: colour bars; MODE change mid-frame must not affect it.
      n = 0;
      while (!busy && n < 20) begin @(posedge clk); #1; n++; end
      check_eq("busy_start", 32'(busy), 32'd1);
      mode = 2'd2;
      wait_fc("fc_frame1", 8'd1);
      check_eq("vsync_len", 32'(vs_len), 32'(V_SYNC * LINE));
      check_eq("href_pulses", 32'(href_pulses), 32'(V_ACT));
      check_eq("href_len", 32'(href_len), 32'(2 * H_ACT));
      check_eq("href_gap", 32'(low_gap), 32'(H_BLANK));
      check_eq("pclk_period", 32'(pclk_period), 32'd2);
      check_eq("bar_px0", 32'(cap[0][0]), 32'h0000FFFF);
      check_eq("bar_px5", 32'(cap[0][5]), 32'h0000FFE0);
      check_eq("bar_px10_y19", 32'(cap[19][10]), 32'h000007FF);
      check_eq("bar_px25", 32'(cap[0][25]), 32'h0000F800);
      check_eq("bar_px30", 32'(cap[0][30]), 32'h0000001F);
      check_eq("bar_px39", 32'(cap[0][39]), 32'h00000000);
      check_eq("busy_b2b", 32'(busy), 32'd1);

      // Frame 2: checker; switch to gray ramp late in the frame.
      wait_vs_rises(2);
      check_eq("frame_period", 32'(frame_period), 32'(FRAME));
      wait_row(17);
      mode = 2'd1;
      wait_fc("fc_frame2", 8'd2);
      check_eq("chk_16_0", 32'(cap[0][16]), 32'h0000FFFF);
      check_eq("chk_16_16", 32'(cap[16][16]), 32'h00000000);
      check_eq("chk_3_16", 32'(cap[16][3]), 32'h0000FFFF);
      check_eq("chk_0_19", 32'(cap[19][0]), 32'h0000FFFF);

      // Frame 3: gray ramp.
      wait_vs_rises(3);
      mode = 2'd3;
      wait_fc("fc_frame3", 8'd3);
      check_eq("gray_px8", 32'(cap[0][8]), 32'h00000841);
      check_eq("gray_px32", 32'(cap[0][32]), 32'h00002104);
      check_eq("gray_px39", 32'(cap[5][39]), 32'h00002124);

      // Frame 4: frame ID, EN dropped mid-frame.
      wait_vs_rises(4);
      wait_row(10);
      en = 1'b0;
      wait_fc("fc_frame4", 8'd4);
      check_eq("en_drop_lines", 32'(href_pulses), 32'(V_ACT));
      check_eq("fid_px", 32'(cap[19][20]), 32'h00000060);
      check_eq("busy_idle", 32'(busy), 32'd0);
      repeat (300) @(posedge clk);
      #1;
      check_eq("no_vsync_idle", 32'(vs_rises), 32'd4);
      check_eq("busy_still_idle", 32'(busy), 32'd0);
      en = 1'b1;
      n = 0;
      while (!vsync && n < 4) begin @(posedge clk); #1; n++; end
      check_eq("restart_vsync", 32'(vsync), 32'd1);
      check_eq("restart_busy", 32'(busy), 32'd1);
      check_eq("pclk3_period", 32'(period3), 32'd6);

      // Reset pulse in the middle of an HREF.
      n = 0;
      while (!hsync && n < 2 * FRAME) begin @(posedge clk); #1; n++; end
      check_eq("href_before_rst", 32'(hsync), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("mid_rst_pclk", 32'(pclk), 32'd0);
      check_eq("mid_rst_vsync", 32'(vsync), 32'd0);
      check_eq("mid_rst_hsync", 32'(hsync), 32'd0);
      check_eq("mid_rst_data", 32'(data), 32'd0);
      check_eq("mid_rst_fc", 32'(fc), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      n = 0;
      while (!vsync && !hsync && n < 100) begin @(posedge clk); #1; n++; end
      check_eq("post_rst_vsync", 32'(vsync), 32'd1);
      check_eq("post_rst_no_href", 32'(hsync), 32'd0);
      check_eq("stray_bytes", 32'(stray), 32'd0);
      check_eq("pclk3_seen", 32'(trans3 != 0), 32'd1);
      check_eq("pclk3_fall_only", 32'(viol3), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cam_pattern_tx.md
Name: cam_pattern_tx

Overview:
Synthesizable camera-sensor emulator. It is the transmit end of the parallel camera interface that our capture path receives: PCLK, VSYNC, HREF and 8-bit RGB565 byte data, with the high byte sent first. It generates QVGA-style frames of selectable test patterns from the system clock. It substitutes for the physical sensor in board bring-up and in closed-loop simulation of the capture, line-buffer and VGA chain.

Parameters:
PCLK_HALF, 1, CLK cycles per PCLK half-period; PCLK = CLK/(2*PCLK_HALF); must be >=1
H_ACT, 320, active pixels per line; each pixel is 2 bytes
H_BLANK, 144, PCLK cycles with HREF low per line; line = 2*H_ACT+H_BLANK PCLK cycles
V_SYNC, 3, lines with VSYNC high
V_BACK, 17, blank lines after VSYNC
V_ACT, 240, active lines
V_FRONT, 10, blank lines before the next VSYNC

Ports:
CLK  in  1  system clock; only clock domain
RST  in  1  synchronous reset, active-high
EN  in  1  frame generation enable
MODE  in  2  pattern select; sampled at frame start
PCLK  out  1  emulated pixel clock; a register output, not used as an internal clock
CamVsync  out  1  high during the V_SYNC lines
CamHsync  out  1  HREF; high while active bytes are on CamData
CamData  out  8  pixel byte; 0x00 whenever CamHsync is low
FrameCount  out  8  completed frames; wraps at 255->0
Busy  out  1  high from frame start until the end of the last V_FRONT line

Behaviour:
- Reset: PCLK=0, CamVsync=0, CamHsync=0, CamData=0x00, FrameCount=0, Busy=0, state=IDLE, all counters=0. Reset mid-line or mid-frame aborts the frame immediately; no partial line is completed.
- PCLK generation:
  - Divider counter runs 0..PCLK_HALF-1; PCLK toggles on wrap. It runs continuously out of reset, including in IDLE.
  - "Fall tick" = the CLK cycle in which PCLK goes 1->0. All of CamVsync, CamHsync, CamData and the internal counters update only on fall ticks, so they are stable across every PCLK rising edge.
- Counters (advance on fall ticks, outside IDLE):
  - bc: byte/PCLK count within a line, 0..2*H_ACT+H_BLANK-1.
  - ln: line within the frame, 0..V_TOTAL-1, where V_TOTAL = V_SYNC+V_BACK+V_ACT+V_FRONT.
  - bc wraps to 0 and ln increments at the end of each line.
- State machine: IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT.
  - IDLE -> VSYNC: on a fall tick with EN=1. On that same tick: latch MODE, set Busy=1, bc=ln=0, CamVsync=1.
  - VSYNC -> VBACK when ln reaches V_SYNC; VBACK -> ACTIVE at ln=V_SYNC+V_BACK; ACTIVE -> VFRONT at ln=V_SYNC+V_BACK+V_ACT.
  - At the end of the last VFRONT line: FrameCount increments. If EN=1, go directly to VSYNC (back-to-back frames, MODE re-latched). Otherwise go to IDLE with Busy=0.
  - Deasserting EN mid-frame never truncates the frame. MODE changes mid-frame take effect only at the next frame.
- Active line data:
  - CamHsync=1 for bc < 2*H_ACT; otherwise CamHsync=0 and CamData=0x00.
  - Pixel x = bc>>1; active line y = ln-(V_SYNC+V_BACK).
  - Even bc sends pix[15:8]; odd bc sends pix[7:0].
  - CamVsync=0 outside the VSYNC state; CamHsync=0 outside the ACTIVE state.
- Patterns (pix is RGB565):
  - MODE 0, colour bars: bar = x/(H_ACT/8). Bars 0..7 are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Any x beyond bar 7 uses 0000.
  - MODE 1, gray ramp: pix = {x[7:3], x[7:2], x[7:3]}.
  - MODE 2, checker: pix = (x[4]^y[4]) ? FFFF : 0000.
  - MODE 3, frame ID: solid pix = {5'h00, FrameCount[5:0], 5'h00}, using FrameCount as latched at frame start.
- Latency: the first HREF byte appears on the fall tick that begins ACTIVE line 0. With defaults, VSYNC rises (V_SYNC+V_BACK)*784 PCLK cycles = 15680 PCLK before the first HREF.

Test Plan:
- Reset, then EN=1, MODE=0, defaults -> PCLK = CLK/2. VSYNC is high for exactly 2352 PCLK. Exactly 240 HREF pulses per frame, each 640 PCLK long with 144 PCLK low between them. Frame period is 270*784 = 211680 PCLK.
- Colour bars, line 0 -> pixel 0 bytes FF,FF; pixel 40 bytes FF,E0; pixel 200 bytes F8,00; pixel 319 bytes 00,00. The receiver-side capture model reassembles these same RGB565 words.
- MODE=2 -> pixel (16,0) = 0xFFFF and pixel (16,16) = 0x0000. Switch MODE to 1 mid-frame -> the remaining lines stay checker, and the next frame has pixel 255 = 0xFFFF and pixel 8 = 0x0841.
- EN dropped at active line 100 -> all 240 lines are still emitted, FrameCount goes 0->1, then Busy=0 with no further VSYNC. EN re-asserted -> a new VSYNC starts on the next fall tick.
- RST pulsed for 1 CLK mid-HREF -> the next CLK has all outputs 0 and FrameCount=0. A new frame starts with VSYNC, and no stray HREF bytes appear.
- PCLK_HALF=3 -> PCLK period is 6 CLK, and CamData/CamHsync transitions occur only in CLK cycles where PCLK falls.
